// File: rtl/lsu_apb_initiator.sv
// LSU APB initiator: one load/store at a time, funct3/alignment check, SETUP/ACCESS transfer.
// Latency: accept T, SETUP T+1, ACCESS T+2 (+1 per wait state), registered response T+3; illegal request responds at T+2.
// Backpressure: req_ready_o only in IDLE; stall_o holds the pipeline from accept until the response cycle.
//
// Ports: clk_i/rst_ni (async active-low); req_* pipeline request; rsp_* one-cycle response pulse;
//        stall_o pipeline hold; psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/pfunct_code_o APB request;
//        prdata_i/pready_i APB completion.
// Optional: define LSU_APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module lsu_apb_initiator #(
   parameter int DMEM_ADDR      = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2:0]            req_funct3_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  stall_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [DMEM_ADDR-1:0]  paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   output logic [2:0]            pfunct_code_o,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pready_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR
   } state_t;

   state_t state_q, state_d;

   logic accept;
   logic req_legal;
   logic access_done;
   logic timeout_abort;

   // Only the word index reaches the bus; the byte offset is used for the alignment check.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:DMEM_ADDR+2];

   assign accept      = (state_q == ST_IDLE) && req_valid_i;
   assign access_done = (state_q == ST_ACCESS) && pready_i;

   // Legality of the incoming request; unsigned loads have no store counterpart.
   always_comb begin
      req_legal = 1'b0;
      case (req_funct3_i)
         3'd0:    req_legal = 1'b1;
         3'd1:    req_legal = ~req_addr_i[0];
         3'd2:    req_legal = (req_addr_i[1:0] == 2'b00);
         3'd4:    req_legal = ~req_we_i;
         3'd5:    req_legal = ~req_we_i & ~req_addr_i[0];
         default: req_legal = 1'b0;
      endcase
   end

`ifdef LSU_APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Abort on the wait cycle that brings the count to TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] to_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_SETUP) begin
         to_cnt_q <= '0;
      end else if ((state_q == ST_ACCESS) && !pready_i) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign timeout_abort = (state_q == ST_ACCESS) && !pready_i && (to_cnt_q == CNT_LAST);
`else
   localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
   assign timeout_abort = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bus strobes and stall decode straight from state so reset releases them immediately.
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      psel_o      = 1'b0;
      penable_o   = 1'b0;
      stall_o     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            stall_o     = req_valid_i;
            if (req_valid_i) begin
               state_d = req_legal ? ST_SETUP : ST_ERR;
            end
         end
         ST_SETUP: begin
            psel_o  = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (pready_i || timeout_abort) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request fields are captured at accept and held until the next accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         paddr_o       <= '0;
         pwrite_o      <= 1'b0;
         pwdata_o      <= '0;
         pfunct_code_o <= '0;
      end else if (accept) begin
         paddr_o       <= req_addr_i[DMEM_ADDR+1:2];
         pwrite_o      <= req_we_i;
         pwdata_o      <= req_wdata_i;
         pfunct_code_o <= req_funct3_i;
      end
   end

   // Response is registered: it appears the cycle after completion, error or abort.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= access_done || timeout_abort || (state_q == ST_ERR);
         rsp_err_o   <= timeout_abort || (state_q == ST_ERR);
         if (access_done) begin
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
         end else if (timeout_abort || (state_q == ST_ERR)) begin
            rsp_rdata_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_apb_initiator.sv
module tb_lsu_apb_initiator;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_we_i;
   logic [31:0] req_wdata_i;
   logic [2:0]  req_funct3_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        stall_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [5:0]  paddr_o;
   logic [31:0] pwdata_o;
   logic [2:0]  pfunct_code_o;
   logic [31:0] prdata_i;
   logic        pready_i;

   int checks = 0;
   int errors = 0;

   lsu_apb_initiator #(
      .DMEM_ADDR     (6),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_we_i     (req_we_i),
      .req_wdata_i  (req_wdata_i),
      .req_funct3_i (req_funct3_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .stall_o      (stall_o),
      .psel_o       (psel_o),
      .penable_o    (penable_o),
      .pwrite_o     (pwrite_o),
      .paddr_o      (paddr_o),
      .pwdata_o     (pwdata_o),
      .pfunct_code_o(pfunct_code_o),
      .prdata_i     (prdata_i),
      .pready_i     (pready_i)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change just after the rising edge; outputs are checked on the falling edge.
   task automatic drive_pt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_pt();
      @(negedge clk_i);
   endtask

   // Cycle T: present a request for one cycle and check the accept-cycle handshake.
   task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [2:0] f3, input string tag);
      drive_pt();
      req_valid_i  = 1'b1;
      req_addr_i   = addr;
      req_we_i     = we;
      req_wdata_i  = wdata;
      req_funct3_i = f3;
      check_pt();
      checks++; if ({req_ready_o, stall_o} !== 2'b11) begin errors++; $display("FAIL %s_accept ready/stall got=%b exp=11", tag, {req_ready_o, stall_o}); end
      drive_pt();
      req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
      req_wdata_i = '0; req_funct3_i = '0; prdata_i = '0; pready_i = 1'b1;
      check_pt();
      checks++; if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, stall_o} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=000000", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, stall_o}); end
      checks++; if ({paddr_o, pwdata_o, pfunct_code_o} !== 41'b0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {paddr_o, pwdata_o, pfunct_code_o}); end
      checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata_o); end
      drive_pt();
      rst_ni = 1'b1;
      check_pt();
      checks++; if ({req_ready_o, stall_o} !== 2'b10) begin errors++; $display("FAIL reset_ready got=%b exp=10", {req_ready_o, stall_o}); end
   endtask

   task automatic test_word_store();
      pready_i = 1'b1;
      issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 3'd2, "sw");
      check_pt(); // T+1 SETUP
      checks++; if ({psel_o, penable_o, stall_o} !== 3'b101) begin errors++; $display("FAIL sw_setup sel/en/stall got=%b exp=101", {psel_o, penable_o, stall_o}); end
      checks++; if ({paddr_o, pwrite_o, pwdata_o, pfunct_code_o} !== {6'd4, 1'b1, 32'hDEAD_BEEF, 3'd2}) begin errors++; $display("FAIL sw_bus got=%h/%b/%h/%0d exp=04/1/deadbeef/2", paddr_o, pwrite_o, pwdata_o, pfunct_code_o); end
      drive_pt(); check_pt(); // T+2 ACCESS
      checks++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin errors++; $display("FAIL sw_access got=%b exp=110", {psel_o, penable_o, rsp_valid_o}); end
      drive_pt(); check_pt(); // T+3 response
      checks++; if ({rsp_valid_o, rsp_err_o, stall_o, psel_o} !== 4'b1000 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL sw_rsp v/e/stall/sel got=%b rdata=%h exp=1000 rdata=0", {rsp_valid_o, rsp_err_o, stall_o, psel_o}, rsp_rdata_o); end
      drive_pt(); check_pt(); // T+4
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL sw_rsp_pulse got=%b exp=0", rsp_valid_o); end
   endtask

   task automatic test_byte_load();
      pready_i = 1'b1; prdata_i = 32'hFFFF_FF80;
      issue(32'h0000_0008, 1'b0, 32'h1234_5678, 3'd0, "lb");
      check_pt(); // T+1
      checks++; if ({paddr_o, pwrite_o, pfunct_code_o} !== {6'd2, 1'b0, 3'd0}) begin errors++; $display("FAIL lb_bus got=%h/%b/%0d exp=02/0/0", paddr_o, pwrite_o, pfunct_code_o); end
      drive_pt(); check_pt(); // T+2
      drive_pt(); check_pt(); // T+3
      checks++; if ({rsp_valid_o, rsp_err_o} !== 2'b10 || rsp_rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rsp got=%b rdata=%h exp=10 rdata=ffffff80", {rsp_valid_o, rsp_err_o}, rsp_rdata_o); end
   endtask

   task automatic test_wait_states();
      pready_i = 1'b0; prdata_i = 32'hA5A5_0F0F;
      issue(32'h0000_0020, 1'b0, 32'h0, 3'd2, "lw");
      check_pt(); // T+1
      for (int c = 2; c <= 4; c++) begin
         drive_pt(); check_pt();
         checks++; if ({psel_o, penable_o, stall_o, rsp_valid_o, paddr_o, pwrite_o, pfunct_code_o} !== {4'b1110, 6'd8, 1'b0, 3'd2}) begin errors++; $display("FAIL lw_wait_c%0d got=%b/%h/%b/%0d exp=1110/08/0/2", c, {psel_o, penable_o, stall_o, rsp_valid_o}, paddr_o, pwrite_o, pfunct_code_o); end
      end
      drive_pt(); pready_i = 1'b1; check_pt(); // T+5
      checks++; if ({stall_o, rsp_valid_o} !== 2'b10) begin errors++; $display("FAIL lw_t5 stall/v got=%b exp=10", {stall_o, rsp_valid_o}); end
      drive_pt(); pready_i = 1'b0; check_pt(); // T+6
      checks++; if ({rsp_valid_o, rsp_err_o, stall_o} !== 3'b100 || rsp_rdata_o !== 32'hA5A5_0F0F) begin errors++; $display("FAIL lw_rsp got=%b rdata=%h exp=100 rdata=a5a50f0f", {rsp_valid_o, rsp_err_o, stall_o}, rsp_rdata_o); end
      pready_i = 1'b1;
   endtask

   task automatic test_illegal(input logic [31:0] addr, input logic we, input logic [2:0] f3, input string tag);
      pready_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
      issue(addr, we, 32'h1111_2222, f3, tag);
      check_pt(); // T+1 ERR
      checks++; if ({psel_o, penable_o, stall_o, rsp_valid_o} !== 4'b0010) begin errors++; $display("FAIL %s_err_cycle got=%b exp=0010", tag, {psel_o, penable_o, stall_o, rsp_valid_o}); end
      drive_pt(); check_pt(); // T+2
      checks++; if ({rsp_valid_o, rsp_err_o, stall_o} !== 3'b110 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL %s_rsp got=%b rdata=%h exp=110 rdata=0", tag, {rsp_valid_o, rsp_err_o, stall_o}, rsp_rdata_o); end
   endtask

   // Illegal request, then a new store accepted in the response cycle.
   task automatic test_back_to_back();
      pready_i = 1'b1;
      issue(32'h0000_0002, 1'b0, 32'h0, 3'd2, "b2b_lw");
      check_pt(); // T+1 ERR
      drive_pt();  // T+2: response cycle, new request presented
      req_valid_i = 1'b1; req_addr_i = 32'h0000_003C; req_we_i = 1'b1;
      req_wdata_i = 32'h0BAD_F00D; req_funct3_i = 3'd0;
      check_pt();
      checks++; if ({rsp_valid_o, rsp_err_o, req_ready_o, stall_o} !== 4'b1111) begin errors++; $display("FAIL b2b_accept got=%b exp=1111", {rsp_valid_o, rsp_err_o, req_ready_o, stall_o}); end
      drive_pt(); req_valid_i = 1'b0; check_pt(); // SETUP
      checks++; if ({rsp_valid_o, psel_o, penable_o, paddr_o, pwdata_o} !== {3'b010, 6'd15, 32'h0BAD_F00D}) begin errors++; $display("FAIL b2b_setup got=%b/%h/%h exp=010/0f/0badf00d", {rsp_valid_o, psel_o, penable_o}, paddr_o, pwdata_o); end
      drive_pt(); check_pt(); // ACCESS
      drive_pt(); check_pt(); // response
      checks++; if ({rsp_valid_o, rsp_err_o, stall_o} !== 3'b100) begin errors++; $display("FAIL b2b_rsp got=%b exp=100", {rsp_valid_o, rsp_err_o, stall_o}); end
   endtask

   task automatic test_timeout();
      pready_i = 1'b0; prdata_i = 32'h7777_7777;
      issue(32'h0000_0000, 1'b0, 32'h0, 3'd2, "to");
      check_pt(); // T+1
`ifdef LSU_APB_TIMEOUT_EN
      for (int c = 2; c <= 5; c++) begin drive_pt(); check_pt(); end
      checks++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin errors++; $display("FAIL to_last_access got=%b exp=110", {psel_o, penable_o, rsp_valid_o}); end
      drive_pt(); check_pt(); // T+6
      checks++; if ({psel_o, penable_o, rsp_valid_o, rsp_err_o, stall_o} !== 5'b00110 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL to_abort got=%b rdata=%h exp=00110 rdata=0", {psel_o, penable_o, rsp_valid_o, rsp_err_o, stall_o}, rsp_rdata_o); end
`else
      for (int c = 2; c <= 21; c++) begin
         drive_pt(); check_pt();
         checks++; if ({psel_o, penable_o, rsp_valid_o, stall_o} !== 4'b1101) begin errors++; $display("FAIL to_wait_c%0d got=%b exp=1101", c, {psel_o, penable_o, rsp_valid_o, stall_o}); end
      end
      drive_pt(); pready_i = 1'b1; check_pt();
      drive_pt(); pready_i = 1'b0; check_pt();
      checks++; if ({rsp_valid_o, rsp_err_o} !== 2'b10 || rsp_rdata_o !== 32'h7777_7777) begin errors++; $display("FAIL to_late_rsp got=%b rdata=%h exp=10 rdata=77777777", {rsp_valid_o, rsp_err_o}, rsp_rdata_o); end
`endif
      pready_i = 1'b1;
   endtask

   task automatic test_reset_in_access();
      pready_i = 1'b0;
      issue(32'h0000_0004, 1'b0, 32'h0, 3'd2, "rst");
      check_pt(); // T+1
      drive_pt(); check_pt(); // T+2 ACCESS wait
      drive_pt(); // T+3 ACCESS wait
      rst_ni = 1'b0;
      #1;
      checks++; if ({psel_o, penable_o, stall_o, rsp_valid_o} !== 4'b0000) begin errors++; $display("FAIL rst_async got=%b exp=0000", {psel_o, penable_o, stall_o, rsp_valid_o}); end
      drive_pt(); pready_i = 1'b1; rst_ni = 1'b1;
      for (int c = 0; c < 2; c++) begin
         check_pt();
         checks++; if ({rsp_valid_o, psel_o, req_ready_o} !== 3'b001) begin errors++; $display("FAIL rst_quiet_c%0d got=%b exp=001", c, {rsp_valid_o, psel_o, req_ready_o}); end
         drive_pt();
      end
      issue(32'h0000_0018, 1'b1, 32'hCAFE_0001, 3'd1, "rst_sh");
      check_pt(); // T+1
      drive_pt(); check_pt(); // T+2
      drive_pt(); check_pt(); // T+3
      checks++; if ({rsp_valid_o, rsp_err_o, paddr_o, pfunct_code_o} !== {2'b10, 6'd6, 3'd1}) begin errors++; $display("FAIL rst_after_rsp got=%b/%h/%0d exp=10/06/1", {rsp_valid_o, rsp_err_o}, paddr_o, pfunct_code_o); end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_load();
      test_wait_states();
      test_illegal(32'h0000_0003, 1'b0, 3'd1, "lh_mis");
      test_illegal(32'h0000_0010, 1'b1, 3'd4, "sw_f4");
      test_illegal(32'h0000_0010, 1'b0, 3'd3, "f3_3");
      test_back_to_back();
      test_timeout();
      test_reset_in_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_apb_initiator.md
Name: lsu_apb_initiator

Overview:
- Initiator (master) end of the LSU's APB-style data-memory/peripheral bus. Sits between the pipeline MEM stage and the memory bank responder.
- Accepts one load/store request at a time from the pipeline and validates alignment and funct3.
- Drives a two-phase SETUP/ACCESS transfer, waits on pready_i, and returns a registered response.
- Stalls the pipeline while a transfer is outstanding.

Parameters:
- DMEM_ADDR, 6, width of paddr_o (word index into the bank).
- DATA_WIDTH, 32, data bus width; fixed at 32 for RV32.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles allowed before abort. Used only with LSU_APB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  pipeline request valid.
- req_ready_o  out  1  initiator can accept a request.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  32  store data, right-aligned.
- req_funct3_i  in  3  RV32 funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  load result as returned by the responder; 0 for stores and errors.
- rsp_err_o  out  1  misaligned/illegal request or timeout; qualified by rsp_valid_o.
- stall_o  out  1  pipeline hold.
- psel_o  out  1  APB select.
- penable_o  out  1  APB access phase.
- pwrite_o  out  1  APB write.
- paddr_o  out  DMEM_ADDR  word index = req_addr_i[DMEM_ADDR+1:2].
- pwdata_o  out  32  write data.
- pfunct_code_o  out  3  funct3 forwarded to the responder.
- prdata_i  in  32  responder read data.
- pready_i  in  1  responder completion.

Behaviour:
- Reset (async, rst_ni low):
  - state = IDLE.
  - psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, stall_o = 0.
  - paddr_o, pwdata_o, pfunct_code_o, rsp_rdata_o = 0.
  - req_ready_o = 1 once reset is released.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture addr, we, wdata, funct3.
  - Legal request → SETUP. Illegal request → ERR.
- Illegal request, any of:
  - funct3 not in {0, 1, 2, 4, 5};
  - store with funct3 in {4, 5};
  - H/HU with addr[0] = 1;
  - W with addr[1:0] != 0.
- SETUP (exactly 1 cycle): psel_o = 1, penable_o = 0, then → ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - While pready_i = 0: stay; all bus outputs held stable.
  - On pready_i = 1: register rsp_rdata_o = prdata_i for loads (0 for stores), assert rsp_valid_o next cycle, → IDLE.
- ERR (1 cycle): no bus activity. rsp_valid_o = 1, rsp_err_o = 1 in the following cycle, rsp_rdata_o = 0. Then → IDLE.
- Bus address/data outputs (paddr_o, pwrite_o, pwdata_o, pfunct_code_o) are registered at accept and held until the next accept.
- Latency with zero wait states:
  - accept at T, SETUP at T+1, ACCESS with pready at T+2, rsp_valid_o at T+3.
  - Each wait cycle adds 1.
- Back-to-back requests: a new request may be accepted in the same cycle rsp_valid_o is high; that cycle is IDLE.
- stall_o = (state != IDLE) || (state == IDLE && req_valid_i).
  - The accept cycle stalls.
  - stall_o falls in the cycle rsp_valid_o rises.
- rsp_valid_o is never high for 2 consecutive cycles unless a second request was accepted.
- Reset mid-transfer: the bus is released immediately (psel_o/penable_o = 0), no response is emitted, and the FSM returns to IDLE.
- pready_i is ignored outside ACCESS.

Optional Feature:
- Macro: LSU_APB_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When it reaches TIMEOUT_CYCLES: drop psel_o/penable_o, → IDLE, pulse rsp_valid_o with rsp_err_o = 1 and rsp_rdata_o = 0.
- Disabled: no counter; ACCESS waits indefinitely for pready_i.

Test Plan:
- Word store: addr 0x0000_0010, SW, wdata 0xDEADBEEF, pready tied 1 → psel_o rises at T+1 and penable_o at T+2, paddr_o = 4, pwrite_o = 1, pwdata_o = 0xDEADBEEF, pfunct_code_o = 2; rsp_valid_o at T+3 with rdata = 0, err = 0.
- Byte load passthrough: LB at addr 0x8, prdata_i = 0xFFFF_FF80 → paddr_o = 2, pfunct_code_o = 0, rsp_rdata_o = 0xFFFF_FF80.
- Wait states: LW with pready low for 3 ACCESS cycles → bus outputs stable throughout, rsp_valid_o at T+6, stall_o high from T through T+5.
- Illegal requests:
  - LH at addr 0x3 → no psel_o; rsp_valid_o = 1, rsp_err_o = 1 at T+2.
  - SW funct3 = 4 → same response.
- Timeout (macro on, TIMEOUT_CYCLES = 4): pready_i held 0 → after 4 ACCESS cycles psel_o drops and rsp_err_o pulses.
- Reset in ACCESS: rst_ni low during a wait state → psel_o, penable_o, stall_o = 0 asynchronously, no rsp_valid_o; a request after release completes normally.
